// File: rtl/moore_trace_driver_if.sv
// Stimulus-load and trace-stream handshake bundle for moore_trace_driver.
// The slave modport is the driver's view; the master modport is the host/consumer view.
interface moore_trace_driver_if #(
   parameter int IN_W  = 2,
   parameter int OUT_W = 2
);
   // stimulus load stream (host -> driver)
   logic             ld_valid;
   logic             ld_ready;
   logic [IN_W-1:0]  ld_sym;

   // trace record stream (driver -> inference tools)
   logic             tr_valid;
   logic             tr_ready;
   logic [IN_W-1:0]  tr_in;
   logic [OUT_W-1:0] tr_out;
   logic             tr_last;

   modport master (
      output ld_valid, ld_sym, tr_ready,
      input  ld_ready, tr_valid, tr_in, tr_out, tr_last
   );

   modport slave (
      input  ld_valid, ld_sym, tr_ready,
      output ld_ready, tr_valid, tr_in, tr_out, tr_last
   );
endinterface

// File: rtl/moore_trace_driver.sv
// Drives a stored input sequence into a Moore FSM, records {input, output} per step
// plus the output after the last transition, then streams the records out.
module moore_trace_driver #(
   parameter int IN_W  = 2,
   parameter int OUT_W = 2,
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic              clk,
   input  logic              reset,      // asynchronous, active-low
   moore_trace_driver_if.slave bus,
   input  logic              clr,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              dut_reset,
   output logic [IN_W-1:0]   dut_in,
   input  logic [OUT_W-1:0]  dut_out
);
   localparam int SIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int REC_W  = IN_W + OUT_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, DUT_RST, DRIVE, FINAL, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] idx_q, idx_d;     // drive step during DRIVE/FINAL, read index during DRAIN
   logic             ran_q, ran_d;     // set once a run has begun; releases dut_reset in IDLE
   logic             done_q, done_d;
   logic             stim_we;
   logic [CNT_W-1:0] idx_inc;

   logic [IN_W-1:0]  stim_mem  [DEPTH];
   logic [REC_W-1:0] trace_mem [DEPTH+1];

   assign idx_inc = idx_q + ONE_C;

   // State register: every control flop, cleared by the asynchronous reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         ran_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         ran_q   <= ran_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: run sequencing, stimulus loading and index stepping
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      ran_d   = ran_q;
      done_d  = 1'b0;
      stim_we = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (len_q != '0)) begin
               state_d = DUT_RST;
               ran_d   = 1'b1;
            end else if (clr) begin
               len_d = '0;
            end else if (bus.ld_valid && (len_q < DEPTH_C)) begin
               stim_we = 1'b1;
               len_d   = len_q + ONE_C;
            end
         end
         DUT_RST: begin
            state_d = DRIVE;
            idx_d   = '0;
         end
         DRIVE: begin
            // idx ends at len, which is where FINAL writes its record
            idx_d = idx_inc;
            if (idx_inc == len_q) state_d = FINAL;
         end
         FINAL: begin
            state_d = DRAIN;
            idx_d   = '0;
         end
         DRAIN: begin
            if (bus.tr_ready) begin
               if (idx_q == len_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: FSM drive, load readiness and the trace presentation
   always_comb begin
      busy         = (state_q != IDLE);
      done         = done_q;
      bus.ld_ready = (state_q == IDLE) && (len_q < DEPTH_C);
      dut_reset    = 1'b0;
      dut_in       = '0;
      bus.tr_valid = 1'b0;
      bus.tr_last  = 1'b0;
      bus.tr_in    = '0;
      bus.tr_out   = '0;
      case (state_q)
         IDLE:    dut_reset = !ran_q;
         DUT_RST: dut_reset = 1'b1;
         DRIVE:   dut_in    = stim_mem[idx_q[SIDX_W-1:0]];
         DRAIN: begin
            bus.tr_valid           = 1'b1;
            bus.tr_last            = (idx_q == len_q);
            {bus.tr_in, bus.tr_out} = trace_mem[idx_q];
         end
         default: ;
      endcase
   end

   // Storage: stimulus append in IDLE, trace capture at the closing edge of DRIVE/FINAL steps
   always_ff @(posedge clk) begin
      if (stim_we) stim_mem[len_q[SIDX_W-1:0]] <= bus.ld_sym;
      if ((state_q == DRIVE) || (state_q == FINAL)) trace_mem[idx_q] <= {dut_in, dut_out};
   end
endmodule

// File: tb/tb_moore_trace_driver.sv
// Self-checking bench: drives a small Moore FSM through moore_trace_driver and checks
// the captured trace against a step-by-step reference of that FSM.
module tb_moore_trace_driver;
   localparam int IN_W  = 2;
   localparam int OUT_W = 2;
   localparam int DEPTH = 16;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             clr = 1'b0;
   logic             start = 1'b0;
   logic             busy, done, dut_reset;
   logic [IN_W-1:0]  dut_in;
   logic [OUT_W-1:0] dut_out;

   int n_vec = 0;
   int n_err = 0;

   logic [1:0] mstim[$];     // stimulus the driver should hold
   logic [3:0] exp_q[$];     // expected {in, out} records

   moore_trace_driver_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

   moore_trace_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .bus(bus), .clr(clr), .start(start),
      .busy(busy), .done(done), .dut_reset(dut_reset), .dut_in(dut_in), .dut_out(dut_out)
   );

   always #5 clk = ~clk;

   // Target FSM: S0 out=1, S1 out=0 (reset state), S2 out=0
   function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic [1:0] in);
      case (s)
         2'd0:    return (in == 2'b00) ? 2'd1 : (in == 2'b10) ? 2'd2 : 2'd0;
         2'd1:    return (in == 2'b10) ? 2'd2 : 2'd1;
         default: return (in == 2'b11) ? 2'd0 : 2'd2;
      endcase
   endfunction

   function automatic logic [1:0] fsm_out(input logic [1:0] s);
      return (s == 2'd0) ? 2'd1 : 2'd0;
   endfunction

   logic [1:0] fsm_s;
   always @(posedge clk) fsm_s <= dut_reset ? 2'd1 : fsm_next(fsm_s, dut_in);
   assign dut_out = fsm_out(fsm_s);

   // Expected trace: walk the FSM from its reset state over the stored stimulus
   function automatic void build_exp();
      logic [1:0] s;
      s = 2'd1;
      exp_q.delete();
      foreach (mstim[i]) begin
         exp_q.push_back({mstim[i], fsm_out(s)});
         s = fsm_next(s, mstim[i]);
      end
      exp_q.push_back({2'b00, fsm_out(s)});
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [1:0] sym);
      bus.ld_valid = 1'b1;
      bus.ld_sym   = sym;
      chk("ld_ready", 32'(bus.ld_ready), 32'(mstim.size() < DEPTH));
      if (mstim.size() < DEPTH) mstim.push_back(sym);
      @(negedge clk);
      bus.ld_valid = 1'b0;
   endtask

   task automatic do_clr(input bit with_ld);
      clr          = 1'b1;
      bus.ld_valid = with_ld;
      bus.ld_sym   = 2'b11;
      @(negedge clk);
      clr          = 1'b0;
      bus.ld_valid = 1'b0;
      mstim.delete();
   endtask

   // mode 0: tr_ready held high, 1: toggled every cycle, 2: random
   task automatic run(input int mode, input bit poke);
      int k, rst_cycles, n_rec, guard, len;
      logic [3:0] cur, prev;
      bit stalled, seen_last;
      len = mstim.size();
      build_exp();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      rst_cycles = 0;
      while (!bus.tr_valid && k < 100) begin
         if (dut_reset) rst_cycles++;
         if (k == 1) chk("busy_after_start", 32'(busy), 32'd1);
         if (k >= 2 && k <= len + 1) chk("dut_in_drive", 32'(dut_in), 32'(mstim[k-2]));
         if (k == len + 2) chk("dut_in_final", 32'(dut_in), 32'd0);
         if (poke && k == 2) begin
            chk("ld_ready_busy", 32'(bus.ld_ready), 32'd0);
            clr = 1'b1; start = 1'b1; bus.ld_valid = 1'b1;
            bus.ld_sym = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         k++;
         clr = 1'b0; start = 1'b0; bus.ld_valid = 1'b0;
      end
      chk("first_tr_valid_latency", 32'(k), 32'(len + 3));
      chk("dut_reset_cycles", 32'(rst_cycles), 32'd1);

      n_rec = 0; guard = 0; stalled = 0; seen_last = 0; prev = '0;
      while (!seen_last && guard < 400) begin
         case (mode)
            0:       bus.tr_ready = 1'b1;
            1:       bus.tr_ready = (guard % 2 == 1);
            default: bus.tr_ready = 1'($urandom_range(0, 1));
         endcase
         cur = {bus.tr_in, bus.tr_out};
         chk("tr_valid_drain", 32'(bus.tr_valid), 32'd1);
         if (stalled) chk("stall_stable", 32'(cur), 32'(prev));
         if (bus.tr_ready) begin
            if (n_rec <= len) begin
               chk($sformatf("rec%0d", n_rec), 32'(cur), 32'(exp_q[n_rec]));
               chk($sformatf("tr_last%0d", n_rec), 32'(bus.tr_last), 32'(n_rec == len));
            end
            if (bus.tr_last) seen_last = 1;
            n_rec++;
            stalled = 0;
         end else begin
            stalled = 1;
            prev = cur;
         end
         @(negedge clk);
         guard++;
      end
      bus.tr_ready = 1'b0;
      chk("record_count", 32'(n_rec), 32'(len + 1));
      chk("done_pulse", 32'(done), 32'd1);
      chk("tr_valid_after", 32'(bus.tr_valid), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("dut_reset_idle_after_run", 32'(dut_reset), 32'd0);
      @(negedge clk);
      chk("done_low", 32'(done), 32'd0);
      $display("run len=%0d mode=%0d poke=%0d records=%0d", len, mode, poke, n_rec);
   endtask

   initial begin
      int n;
      bus.ld_valid = 1'b0;
      bus.ld_sym   = '0;
      bus.tr_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tr_valid", 32'(bus.tr_valid), 32'd0);
      chk("rst_dut_in", 32'(dut_in), 32'd0);
      chk("rst_dut_reset", 32'(dut_reset), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("pre_run_dut_reset", 32'(dut_reset), 32'd1);
      chk("idle_ld_ready", 32'(bus.ld_ready), 32'd1);

      // Directed sequence 10,10,11 -> (10,0),(10,0),(11,0),(00,1)
      load(2'b10); load(2'b10); load(2'b11);
      run(0, 0);
      // Re-run without reloading
      run(0, 0);
      // Stalling consumer
      run(1, 0);
      // clr/start/ld_valid while busy are ignored
      run(2, 1);

      // clr beats ld_valid; start with empty stimulus is ignored
      do_clr(1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_len0_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("start_len0_busy2", 32'(busy), 32'd0);
      repeat (5) load(2'($urandom_range(0, 3)));
      run(2, 0);

      // Overfill: 18 offered, 16 kept
      do_clr(1'b0);
      repeat (DEPTH + 2) load(2'($urandom_range(0, 3)));
      chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
      run(2, 0);

      // Random lengths and consumer patterns
      for (int r = 0; r < 4; r++) begin
         do_clr(1'b0);
         n = $urandom_range(1, DEPTH);
         repeat (n) load(2'($urandom_range(0, 3)));
         run(int'($urandom_range(0, 2)), 1'b0);
      end

      // Reset during DRIVE step 2
      do_clr(1'b0);
      repeat (6) load(2'($urandom_range(0, 3)));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("drive_step2_dut_in", 32'(dut_in), 32'(mstim[2]));
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_tr_valid", 32'(bus.tr_valid), 32'd0);
      chk("midrst_dut_reset", 32'(dut_reset), 32'd1);
      chk("midrst_dut_in", 32'(dut_in), 32'd0);
      reset = 1'b1;
      mstim.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("midrst_len0_start", 32'(busy), 32'd0);
      chk("midrst_dut_reset_held", 32'(dut_reset), 32'd1);
      repeat (3) load(2'($urandom_range(0, 3)));
      run(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
